dff_shreg_sp: RTL and testbench
===============================

DFF_SHREG_SP -- requirements
Module: dff_shreg_sp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH      8    register width in bits, legal range 2..64
  RESET_VAL  0    value loaded into q on Reset, WIDTH bits
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk    input   1                     rising-edge clock, the only clock
  Reset  input   1                     synchronous reset, active-high
  Set    input   1                     synchronous preset to all-ones, active-high
  en     input   1                     operation enable; 0 = hold
  mode   input   2                     00 hold, 01 parallel load, 10 shift left, 11 shift right
  d      input   WIDTH                 parallel load data
  sin    input   1                     serial input bit
  q      output  WIDTH                 register contents
  n_q    output  WIDTH                 bitwise complement of q
  sout   output  1                     last bit shifted out
  cnt    output  $clog2(WIDTH+1)       shifts since last load, Reset or Set
  done   output  1                     one-cycle pulse on the WIDTH-th shift
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high on port Reset, sampled only on the rising edge of clk.
REQ-004 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-005 Priority on each rising edge SHALL be: Reset > Set > en=0 > mode.
REQ-006 Set=1 (Reset=0) SHALL give: q = all ones, n_q = all zeros, cnt = 0, done = 0, sout = 0.
REQ-007 en=0 or mode=00 SHALL hold q, n_q, sout and cnt, and SHALL drive done = 0.
REQ-008 mode=01 (parallel load) SHALL give: q = d, n_q = ~d, cnt = 0, done = 0, sout unchanged.
REQ-009 mode=10 (shift left) SHALL give: q = {q[WIDTH-2:0], sin} and sout = old q[WIDTH-1].
REQ-010 mode=11 (shift right) SHALL give: q = {sin, q[WIDTH-1:1]} and sout = old q[0].
REQ-011 n_q SHALL equal ~q on every cycle, including the cycle after reset, set, load and shift.
REQ-012 On each shift, cnt SHALL increment by 1 when old cnt < WIDTH-1.
REQ-013 On a shift with old cnt = WIDTH-1, cnt SHALL wrap to 0 and done SHALL be 1 for exactly the next cycle.
REQ-014 done SHALL be 0 on every cycle that does not complete a WIDTH-th shift.
REQ-015 Consecutive WIDTH-shift groups SHALL each produce one done pulse, with no dead cycle between groups.
REQ-016 Mixing left and right shifts SHALL count identically; cnt SHALL count shifts regardless of direction.
REQ-017 A load, Set or Reset in the middle of a shift sequence SHALL clear cnt to 0, so the next done needs WIDTH fresh shifts.
REQ-018 Set and Reset asserted together SHALL behave as Reset alone.
REQ-019 mode and d SHALL have no effect while Reset, Set or en=0 wins priority.

Reset
REQ-020 Reset=1 at a rising edge SHALL give: q = RESET_VAL, n_q = ~RESET_VAL, sout = 0, cnt = 0, done = 0, independent of all other inputs.
REQ-021 Before the first Reset, output values SHALL be undefined; the bench SHALL apply Reset for at least 1 cycle first.
REQ-022 Deasserting Reset SHALL allow normal operation from the very next rising edge.

Verification (WIDTH=8, RESET_VAL=8'h00)
REQ-023 The bench SHALL cover: Reset=1 with Set=1, en=1, mode=01, d=8'hFF -> q=8'h00, n_q=8'hFF, cnt=0, done=0, sout=0.
REQ-024 The bench SHALL cover: load 8'hA5, then 8 shift-left cycles with sin=1 -> q=8'hFF after cycle 8; sout sequence 1,0,1,0,0,1,0,1; done=1 only after cycle 8; cnt back to 0.
REQ-025 The bench SHALL cover: load 8'h81, then shift right with sin=0 -> q=8'h40, sout=1, cnt=1; then en=0 for 3 cycles -> q, sout and cnt unchanged, done=0.
REQ-026 The bench SHALL cover: 5 shifts, then load 8'h3C, then 7 shifts -> no done pulse; the 8th shift -> done pulse for 1 cycle.
REQ-027 The bench SHALL cover: Set=1 after 6 shifts -> q=8'hFF, n_q=8'h00, cnt=0, sout=0; then 16 continuous shifts -> exactly 2 done pulses, 8 cycles apart.
REQ-028 The bench SHALL check n_q == ~q on every cycle of every scenario, and SHALL repeat scenario REQ-024 with WIDTH=2 and with WIDTH=13.

Source files
------------

// File: rtl/dff_shreg_sp.sv
// rtl/dff_shreg_sp.sv - loadable left/right shift register with shift counter and group-done pulse
module dff_shreg_sp #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         Set,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             n_q,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_RIGHT = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_nq;
  logic             r_sout;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_shift;

  // Next state for the enabled, non-preset case; hold is the default and done only survives one cycle
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    w_shift    = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          w_q_nxt   = d;
          w_cnt_nxt = '0;
        end
        MODE_LEFT: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin};
          w_sout_nxt = r_q[WIDTH-1];
          w_shift    = 1'b1;
        end
        MODE_RIGHT: begin
          w_q_nxt    = {sin, r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
          w_shift    = 1'b1;
        end
        default: ;
      endcase
    end
    // Direction does not matter for counting; the WIDTH-th shift wraps and fires done
    if (w_shift) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt  = '0;
        w_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // State registers; Reset beats Set, both beat everything else, n_q is registered alongside q
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_q    <= RESET_VAL;
      r_nq   <= ~RESET_VAL;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (Set) begin
      r_q    <= '1;
      r_nq   <= '0;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_nq   <= ~w_q_nxt;
      r_sout <= w_sout_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q    = r_q;
  assign n_q  = r_nq;
  assign sout = r_sout;
  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_dff_shreg_sp.sv
// tb/tb_dff_shreg_sp.sv - self-checking bench for dff_shreg_sp at WIDTH 8, 2 and 13
module tb_dff_shreg_sp;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Set = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [63:0] d = 64'h0;
  logic        sin = 1'b0;

  logic [7:0]  q8, nq8;
  logic [1:0]  q2, nq2;
  logic [12:0] q13, nq13;
  logic        sout8, sout2, sout13;
  logic [3:0]  cnt8, cnt13;
  logic [1:0]  cnt2;
  logic        done8, done2, done13;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dff_shreg_sp #(.WIDTH(8), .RESET_VAL(8'h00)) u_w8 (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d[7:0]), .sin(sin),
    .q(q8), .n_q(nq8), .sout(sout8), .cnt(cnt8), .done(done8));

  dff_shreg_sp #(.WIDTH(2), .RESET_VAL(2'b00)) u_w2 (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d[1:0]), .sin(sin),
    .q(q2), .n_q(nq2), .sout(sout2), .cnt(cnt2), .done(done2));

  dff_shreg_sp #(.WIDTH(13), .RESET_VAL(13'h0)) u_w13 (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d[12:0]), .sin(sin),
    .q(q13), .n_q(nq13), .sout(sout13), .cnt(cnt13), .done(done13));

  // DUT outputs gathered per instance, zero-extended
  int          wd [3] = '{8, 2, 13};
  logic [63:0] a_q [3];
  logic [63:0] a_nq [3];
  logic [63:0] a_cnt [3];
  logic        a_sout [3];
  logic        a_done [3];

  assign a_q[0] = 64'(q8);   assign a_nq[0] = 64'(nq8);   assign a_cnt[0] = 64'(cnt8);
  assign a_q[1] = 64'(q2);   assign a_nq[1] = 64'(nq2);   assign a_cnt[1] = 64'(cnt2);
  assign a_q[2] = 64'(q13);  assign a_nq[2] = 64'(nq13);  assign a_cnt[2] = 64'(cnt13);
  assign a_sout[0] = sout8;  assign a_sout[1] = sout2;    assign a_sout[2] = sout13;
  assign a_done[0] = done8;  assign a_done[1] = done2;    assign a_done[2] = done13;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register value as an integer, shift count kept modulo width
  logic [63:0] m_q [3];
  logic        m_sout [3];
  int          m_cnt [3];
  logic        m_done [3];
  bit          m_valid = 1'b0;

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [63:0] mk;
      mk = mask_of(wd[k]);
      if (Reset) begin
        m_q[k] = 64'h0; m_sout[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else if (Set) begin
        m_q[k] = mk; m_sout[k] = 1'b0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else if (!en || mode == 2'b00) begin
        m_done[k] = 1'b0;
      end else if (mode == 2'b01) begin
        m_q[k] = d & mk; m_cnt[k] = 0; m_done[k] = 1'b0;
      end else begin
        if (mode == 2'b10) begin
          m_sout[k] = (m_q[k] >> (wd[k] - 1)) & 64'd1;
          m_q[k] = ((m_q[k] * 2) + 64'(sin)) & mk;
        end else begin
          m_sout[k] = m_q[k][0];
          m_q[k] = (m_q[k] / 2) + (64'(sin) << (wd[k] - 1));
        end
        m_cnt[k] = m_cnt[k] + 1;
        m_done[k] = (m_cnt[k] == wd[k]);
        if (m_cnt[k] == wd[k]) m_cnt[k] = 0;
      end
    end
    if (Reset) m_valid = 1'b1;
  end

  // Per-cycle comparison of all three instances against the model
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("w%0d q", wd[k]), a_q[k], m_q[k]);
        chk($sformatf("w%0d n_q", wd[k]), a_nq[k], ~m_q[k] & mask_of(wd[k]));
        chk($sformatf("w%0d n_q==~q", wd[k]), a_nq[k], ~a_q[k] & mask_of(wd[k]));
        chk($sformatf("w%0d sout", wd[k]), 64'(a_sout[k]), 64'(m_sout[k]));
        chk($sformatf("w%0d cnt", wd[k]), a_cnt[k], 64'(m_cnt[k]));
        chk($sformatf("w%0d done", wd[k]), 64'(a_done[k]), 64'(m_done[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic e, input logic [1:0] m,
                       input logic [63:0] dv, input logic si);
    Reset = r; Set = s; en = e; mode = m; d = dv; sin = si;
  endtask

  logic [7:0] exp_sout_seq;
  int         done_steps [$];

  initial begin
    // Reset together with Set, load request and all-ones data: Reset wins
    drive(1, 1, 1, 2'b01, 64'hFF, 1);
    step();
    chk("rst q", 64'(q8), 64'h00);
    chk("rst n_q", 64'(nq8), 64'hFF);
    chk("rst cnt", 64'(cnt8), 64'h0);
    chk("rst done", 64'(done8), 64'h0);
    chk("rst sout", 64'(sout8), 64'h0);

    // Load A5 then 8 left shifts of 1
    drive(0, 0, 1, 2'b01, 64'hA5, 0);
    step();
    chk("load a5 q", 64'(q8), 64'hA5);
    exp_sout_seq = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 2'b10, 64'h0, 1);
      step();
      chk($sformatf("shl a5 sout[%0d]", i), 64'(sout8), 64'(exp_sout_seq[7-i]));
      chk($sformatf("shl a5 done[%0d]", i), 64'(done8), (i == 7) ? 64'd1 : 64'd0);
    end
    chk("shl a5 q", 64'(q8), 64'hFF);
    chk("shl a5 cnt", 64'(cnt8), 64'h0);

    // Load 81, one right shift of 0, then hold with en=0 while mode/d try to load
    drive(0, 0, 1, 2'b01, 64'h81, 0);
    step();
    drive(0, 0, 1, 2'b11, 64'h0, 0);
    step();
    chk("shr 81 q", 64'(q8), 64'h40);
    chk("shr 81 sout", 64'(sout8), 64'h1);
    chk("shr 81 cnt", 64'(cnt8), 64'h1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 2'b01, 64'h00, 1);
      step();
      chk("hold q", 64'(q8), 64'h40);
      chk("hold sout", 64'(sout8), 64'h1);
      chk("hold cnt", 64'(cnt8), 64'h1);
      chk("hold done", 64'(done8), 64'h0);
    end

    // 5 shifts, load 3C mid-sequence, then 8 fresh shifts needed for done
    drive(0, 0, 1, 2'b01, 64'h00, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 2'b10, 64'h0, i[0]);
      step();
    end
    drive(0, 0, 1, 2'b01, 64'h3C, 0);
    step();
    chk("load 3c cnt", 64'(cnt8), 64'h0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 2'b11, 64'h0, 1);
      step();
      chk($sformatf("reload done[%0d]", i), 64'(done8), (i == 7) ? 64'd1 : 64'd0);
    end
    drive(0, 0, 1, 2'b00, 64'h0, 0);
    step();
    chk("reload done cleared", 64'(done8), 64'h0);

    // 6 shifts, Set mid-sequence, then 16 continuous mixed-direction shifts
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 2'b10, 64'h0, 0);
      step();
    end
    drive(0, 1, 1, 2'b10, 64'h0, 0);
    step();
    chk("set q", 64'(q8), 64'hFF);
    chk("set n_q", 64'(nq8), 64'h00);
    chk("set cnt", 64'(cnt8), 64'h0);
    chk("set sout", 64'(sout8), 64'h0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 1, i[0] ? 2'b10 : 2'b11, 64'h0, i[1]);
      step();
      if (done8) done_steps.push_back(i);
    end
    chk("set+16 done count", 64'(done_steps.size()), 64'd2);
    if (done_steps.size() == 2) begin
      chk("set+16 first done", 64'(done_steps[0]), 64'd8);
      chk("set+16 spacing", 64'(done_steps[1] - done_steps[0]), 64'd8);
    end

    // Load A5 then 13 left shifts of 1, pinning the 2- and 13-bit instances
    drive(0, 0, 1, 2'b01, 64'hA5, 0);
    step();
    chk("w2 load q", 64'(q2), 64'h1);
    chk("w13 load q", 64'(q13), 64'h0A5);
    for (int i = 1; i <= 13; i++) begin
      drive(0, 0, 1, 2'b10, 64'h0, 1);
      step();
      if (i == 1) chk("w2 sout1", 64'(sout2), 64'h0);
      if (i == 2) begin
        chk("w2 sout2", 64'(sout2), 64'h1);
        chk("w2 q", 64'(q2), 64'h3);
        chk("w2 done", 64'(done2), 64'h1);
      end
      if (i == 8) chk("w13 q after 8", 64'(q13), 64'h05FF);
      if (i == 12) chk("w13 no done at 12", 64'(done13), 64'h0);
    end
    chk("w13 q", 64'(q13), 64'h1FFF);
    chk("w13 done", 64'(done13), 64'h1);
    chk("w13 cnt", 64'(cnt13), 64'h0);
    chk("w8 cnt after 13", 64'(cnt8), 64'h5);

    drive(0, 0, 1, 2'b00, 64'h0, 0);
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
